plantard_precomp: RTL and testbench
===================================

Name: plantard_precomp

Overview:
- Upstream precomputation stage for the Plantard modular multiplier (plantard_s).
- Inputs: 64-bit odd modulus q and 64-bit operand b.
- Outputs: qinv = q^-1 mod 2^128 (Newton iteration) and the 128-bit Plantard constant b_out = b*qinv mod 2^128, which drives the multiplier's 128-bit b port.
- Iterative and area-lean: one radix-2 serial 128-bit truncated multiplier is shared across all steps.

Parameters:
- W, 64, width of q and b; internal modulus is 2^(2W).
- ITERS, 6, Newton iterations; seed x0=q gives 3 correct bits, and 3*2^6 >= 2W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset: sampled on the rising clk edge, 0 = reset.
- start  input  1  request; sampled only in IDLE.
- q  input  W  modulus; captured when start is accepted.
- b  input  W  operand; captured when start is accepted.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle pulse; result valid.
- err  output  1  one-cycle pulse, together with done, when q is even.
- qinv  output  2W  q^-1 mod 2^(2W); held until next accepted start.
- b_out  output  2W  b*qinv mod 2^(2W); held until next accepted start.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE.
  - busy, done, err, qinv, b_out and all internal registers go to 0.
  - Reset overrides everything, including an operation in progress; no done is produced for an aborted operation.
- States: IDLE, MUL1, MUL2, FIN, DONE.
- IDLE:
  - On start=1 with q[0]=1: latch q and b zero-extended to 2W, set x=q, load multiplier (X=q, Y=x), iteration count it=0, busy=1, go to MUL1.
  - On start=1 with q[0]=0: go to DONE with err=1 and qinv=b_out=0.
- Serial multiplier, 2W cycles per product, all arithmetic mod 2^(2W):
  - Each cycle: acc += Y[0] ? X : 0; X <<= 1; Y >>= 1.
  - acc clears when operands are loaded.
- MUL1: computes t = q*x. On the last cycle it forms u = (2 - t_final) mod 2^(2W) combinationally, loads (X=x, Y=u) and goes to MUL2 with no bubble cycle.
- MUL2: computes x' = x*u. On the last cycle it writes x=x', increments it, then:
  - if it < ITERS: reload (X=q, Y=x') and go to MUL1;
  - else: load (X=b, Y=x') and go to FIN.
- FIN: computes b*x. On the last cycle it registers qinv=x and b_out=product, and goes to DONE.
- DONE: done=1 (and err if applicable) for exactly one cycle, busy drops in the same cycle, then IDLE.
- Latency: done is high in the cycle after the (2*ITERS+1)*2W = 1664th rising edge following the accepting edge. The even-q path takes 1 cycle.
- start while busy or in DONE: ignored, not queued. start held high in IDLE on the cycle after DONE begins a new operation.
- q and b may change freely after acceptance; the block uses only the latched copies.
- Invariants checked at done with err=0:
  - (q*qinv) mod 2^128 == 1;
  - b_out == (b*qinv) mod 2^128.
- Outputs hold their values between done and the next acceptance. They are cleared only by reset, or by an even-q result.

Test Plan:
- q=1, b=1046808672121123921, start pulse → done at 1664 cycles; qinv=1, b_out=1046808672121123921, err=0.
- q=3, b=3 → qinv=0xAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAB, b_out=1.
- q=9223336852482686977, b=1046808672121123921 → (q*qinv) mod 2^128 == 1 and b_out == b*qinv mod 2^128 against the bench model. Chain b_out into plantard_s (a=1046808672121123921, k1=18, k2=0, m=45) and compare against the model Plantard product.
- q=2 → done and err pulse together one cycle after acceptance; qinv=b_out=0; busy never stays high.
- Pulse start again at cycle 500 of a busy operation with different q/b → ignored; the result matches the first request.
- Assert rst=0 at cycle 800, release, then start with q=3, b=6 → no done for the aborted run; new result b_out=2 after 1664 cycles.

Source files
------------

// File: rtl/plantard_precomp.sv
// plantard_precomp: precomputation for the Plantard multiplier.
// It forms qinv = q^-1 mod 2^(2W) by Newton iteration (x <- x*(2 - q*x)), starting
// from x0 = q. It then forms b_out = b*qinv mod 2^(2W). A single radix-2 serial
// multiplier, truncated to 2W bits, is shared by every product.
module plantard_precomp #(
   parameter int W     = 64,
   parameter int ITERS = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   q,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [2*W-1:0] qinv,
   output logic [2*W-1:0] b_out
);
   localparam int DW = 2 * W;
   localparam int CW = $clog2(DW);
   localparam int IW = $clog2(ITERS + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
   localparam logic [IW-1:0] IT_MAX   = IW'(ITERS);
   localparam logic [DW-1:0] TWO      = DW'(2);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL1 = 3'd1;
   localparam logic [2:0] S_MUL2 = 3'd2;
   localparam logic [2:0] S_FIN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] qm_q, qm_d;      // latched modulus, zero-extended
   logic [DW-1:0] bm_q, bm_d;      // latched operand, zero-extended
   logic [DW-1:0] x_q, x_d;        // current inverse approximation
   logic [DW-1:0] mx_q, mx_d;      // multiplicand, shifted left each cycle
   logic [DW-1:0] my_q, my_d;      // multiplier, shifted right each cycle
   logic [DW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] it_q, it_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [DW-1:0] qinv_q, qinv_d;
   logic [DW-1:0] bout_q, bout_d;

   logic [DW-1:0] q_ext, b_ext, addend, prod;
   logic [IW-1:0] it_inc;
   logic          last_cyc;

   assign q_ext    = {{W{1'b0}}, q};
   assign b_ext    = {{W{1'b0}}, b};
   assign addend   = my_q[0] ? mx_q : '0;
   // prod is the accumulator after this cycle's partial product; on the last
   // cycle it is the finished product, so consumers need no bubble cycle.
   assign prod     = acc_q + addend;
   assign last_cyc = (cnt_q == CNT_LAST);
   assign it_inc   = it_q + IW'(1);

   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign qinv  = qinv_q;
   assign b_out = bout_q;

   // Next-state logic: sequencing plus one serial-multiplier step per cycle
   always_comb begin
      state_d = state_q;
      qm_d    = qm_q;
      bm_d    = bm_q;
      x_d     = x_q;
      mx_d    = mx_q;
      my_d    = my_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      it_d    = it_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      qinv_d  = qinv_q;
      bout_d  = bout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (q[0]) begin
                  qm_d    = q_ext;
                  bm_d    = b_ext;
                  x_d     = q_ext;   // q*q == 1 mod 8, so 3 bits are already correct
                  mx_d    = q_ext;
                  my_d    = q_ext;
                  acc_d   = '0;
                  cnt_d   = '0;
                  it_d    = '0;
                  busy_d  = 1'b1;
                  state_d = S_MUL1;
               end else begin
                  // An even q has no inverse: report at once and clear the results.
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  qinv_d  = '0;
                  bout_d  = '0;
                  state_d = S_DONE;
               end
            end
         end

         S_MUL1, S_MUL2, S_FIN: begin
            acc_d = prod;
            mx_d  = mx_q << 1;
            my_d  = my_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (last_cyc) begin
               cnt_d = '0;
               acc_d = '0;
               if (state_q == S_MUL1) begin
                  // t = q*x is done; the correction factor is u = 2 - t.
                  mx_d    = x_q;
                  my_d    = TWO - prod;
                  state_d = S_MUL2;
               end else if (state_q == S_MUL2) begin
                  x_d  = prod;
                  it_d = it_inc;
                  my_d = prod;
                  if (it_inc < IT_MAX) begin
                     mx_d    = qm_q;
                     state_d = S_MUL1;
                  end else begin
                     mx_d    = bm_q;
                     state_d = S_FIN;
                  end
               end else begin
                  qinv_d  = x_q;
                  bout_d  = prod;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         qm_q    <= '0;
         bm_q    <= '0;
         x_q     <= '0;
         mx_q    <= '0;
         my_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         it_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         qinv_q  <= '0;
         bout_q  <= '0;
      end else begin
         state_q <= state_d;
         qm_q    <= qm_d;
         bm_q    <= bm_d;
         x_q     <= x_d;
         mx_q    <= mx_d;
         my_q    <= my_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         it_q    <= it_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         qinv_q  <= qinv_d;
         bout_q  <= bout_d;
      end
   end

endmodule

// File: tb/tb_plantard_precomp.sv
// Directed bench for plantard_precomp. Expected results are queued when a request
// is issued and are checked when done appears.
module tb_plantard_precomp;
   localparam int W = 64;
   localparam int LAT = 1664;
   localparam logic [127:0] INV3 = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAB;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  q_i = '0;
   logic [W-1:0]  b_i = '0;
   logic          busy, done, err;
   logic [127:0]  qinv, b_out;

   always #5 clk = ~clk;

   plantard_precomp #(.W(W), .ITERS(6)) dut (
      .clk(clk), .rst(rst), .start(start), .q(q_i), .b(b_i),
      .busy(busy), .done(done), .err(err), .qinv(qinv), .b_out(b_out)
   );

   typedef struct packed {
      logic [127:0] q;
      logic [127:0] b;
      logic [127:0] qinv;
      logic [127:0] bout;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int saved_cnt;

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   // Hensel lifting, one bit at a time: if bit i of q*x is 1, adding 2^i to x clears it.
   function automatic logic [127:0] inv_model(input logic [127:0] qq);
      logic [127:0] x;
      logic [127:0] t;
      x = 128'd1;
      for (int i = 1; i < 128; i++) begin
         t = qq * x;
         if (t[i]) x[i] = 1'b1;
      end
      return x;
   endfunction

   function automatic exp_t mk_exp(input logic [63:0] qv, input logic [63:0] bv);
      exp_t e;
      e.q = {64'd0, qv};
      e.b = {64'd0, bv};
      if (!qv[0]) begin
         e.qinv = '0; e.bout = '0; e.err = 1'b1;
      end else begin
         e.qinv = inv_model(e.q);
         e.bout = e.b * e.qinv;
         e.err  = 1'b0;
      end
      return e;
   endfunction

   function automatic exp_t mk_lit(input logic [63:0] qv, input logic [63:0] bv,
                                   input logic [127:0] iv, input logic [127:0] ov);
      exp_t e;
      e.q = {64'd0, qv}; e.b = {64'd0, bv}; e.qinv = iv; e.bout = ov; e.err = 1'b0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request; the next rising edge is the accepting edge.
   task automatic start_op(input logic [63:0] qv, input logic [63:0] bv,
                           input bit hold, input bit push, input exp_t e);
      @(negedge clk);
      q_i = qv; b_i = bv; start = 1'b1;
      if (push) sb.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) begin
         start = 1'b0;
         q_i = ~qv; b_i = ~bv;   // only the latched copies may matter now
      end
   endtask

   // Called just after an edge taken as reference 0; expects done after edge exp_n.
   task automatic wait_done(input int exp_n, input string tag);
      int n;
      exp_t e;
      logic [127:0] pr;
      n = 0;
      @(negedge clk);
      if (exp_n > 0) chk({tag, "/busy"}, {127'd0, busy}, 128'd1);
      while (!done && n < exp_n + 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk({tag, "/done_seen"}, {127'd0, done}, 128'd1);
      if (!done) return;
      chk({tag, "/latency"}, 128'(n), 128'(exp_n));
      chk({tag, "/sb_nonempty"}, 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "/err"}, {127'd0, err}, {127'd0, e.err});
         chk({tag, "/qinv"}, qinv, e.qinv);
         chk({tag, "/b_out"}, b_out, e.bout);
         if (!e.err) begin
            pr = e.q * qinv;
            chk({tag, "/q_x_qinv"}, pr, 128'd1);
            pr = e.b * qinv;
            chk({tag, "/b_x_qinv"}, b_out, pr);
         end
      end
      chk({tag, "/busy_at_done"}, {127'd0, busy}, 128'd0);
      @(negedge clk);
      chk({tag, "/done_pulse"}, {127'd0, done}, 128'd0);
      chk({tag, "/err_pulse"}, {127'd0, err}, 128'd0);
   endtask

   initial begin
      exp_t e;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst/busy", {127'd0, busy}, 128'd0);
      chk("rst/done", {127'd0, done}, 128'd0);
      chk("rst/err", {127'd0, err}, 128'd0);
      chk("rst/qinv", qinv, 128'd0);
      chk("rst/b_out", b_out, 128'd0);
      rst = 1'b1;

      // q = 1: the inverse is 1 and b passes straight through
      e = mk_lit(64'd1, 64'd1046808672121123921, 128'd1, 128'd1046808672121123921);
      start_op(64'd1, 64'd1046808672121123921, 1'b0, 1'b1, e);
      wait_done(LAT, "q1");

      // q = 3, b = 3: the inverse is 0xAA..AB and b*qinv = 1
      e = mk_lit(64'd3, 64'd3, INV3, 128'd1);
      start_op(64'd3, 64'd3, 1'b0, 1'b1, e);
      wait_done(LAT, "q3");
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("hold/qinv", qinv, INV3);
      chk("hold/b_out", b_out, 128'd1);

      // Large prime-like modulus, with start held high through done
      e = mk_exp(64'd9223336852482686977, 64'd1046808672121123921);
      start_op(64'd9223336852482686977, 64'd1046808672121123921, 1'b1, 1'b1, e);
      wait_done(LAT, "big");
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(LAT, "held_start");

      // Even modulus: immediate error with cleared results
      e = mk_exp(64'd2, 64'd5);
      start_op(64'd2, 64'd5, 1'b0, 1'b1, e);
      wait_done(0, "even");

      // A second start while busy is ignored
      e = mk_exp(64'd5, 64'd11);
      start_op(64'd5, 64'd11, 1'b0, 1'b1, e);
      repeat (499) @(posedge clk);
      start_op(64'd7, 64'd13, 1'b0, 1'b0, e);
      wait_done(LAT - 500, "ignored");

      // Reset in the middle of an operation aborts it without a done
      e = mk_exp(64'd9, 64'd4);
      start_op(64'd9, 64'd4, 1'b0, 1'b0, e);
      repeat (799) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort/busy", {127'd0, busy}, 128'd0);
      chk("abort/done", {127'd0, done}, 128'd0);
      chk("abort/qinv", qinv, 128'd0);
      chk("abort/b_out", b_out, 128'd0);
      rst = 1'b1;
      saved_cnt = done_cnt;
      e = mk_lit(64'd3, 64'd6, INV3, 128'd2);
      start_op(64'd3, 64'd6, 1'b0, 1'b1, e);
      wait_done(LAT, "after_abort");
      chk("after_abort/done_count", 128'(done_cnt), 128'(saved_cnt + 1));
      chk("sb_empty", 128'(sb.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
